// File: rtl/lsu_mem_port.sv
// lsu_mem_port
// Load/store unit sitting behind the ALU address path. Accepts one request
// (effective address, store data, packed instruction field), runs a single
// word-aligned transfer on the data-memory bus and reports either an extended
// load result or one of three exception flags.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle request, honoured only when idle
//   instruction[16:0]     {funct7, funct3, opcode}
//   addr[31:0]            effective address
//   store_data[31:0]      rs2 value
//   busy                  high whenever not idle
//   done                  one-cycle completion pulse
//   load_data[31:0]       extended load result, valid with done
//   misaligned            access size / address mismatch, valid with done
//   illegal_instruction   unsupported opcode/funct3, valid with done
//   bus_error             bus handshake timed out, valid with done
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   bus request side
//   mem_ready/mem_rdata   bus response side
//   state_dbg[1:0]        current FSM state (IDLE=0, REQ=1, DONE=2)
//   instr_dbg[16:0]       instruction field latched for the current request
//
// Bus handshake: mem_req is held high together with stable mem_addr, mem_we,
// mem_wstrb and mem_wdata until a rising edge where mem_req and mem_ready are
// both 1; that edge completes the transfer and, for loads, captures mem_rdata.
// If TIMEOUT_CYCLES request cycles pass without mem_ready the request is
// withdrawn and bus_error is reported; a late mem_ready is then ignored.

module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal_instruction,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg,
  output logic [16:0] instr_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]  state_q, state_d;
  logic [16:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sd_q, sd_d;
  logic        we_q, we_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;
  logic        berr_q, berr_d;

  // Decode of the incoming request (used only on the accepting cycle).
  logic [6:0] in_op;
  logic [2:0] in_f3;
  logic       in_load, in_store, in_illegal, in_misaligned;

  always_comb begin
    in_op    = instruction[6:0];
    in_f3    = instruction[9:7];
    in_load  = 1'b0;
    in_store = 1'b0;
    if (in_op == OP_LOAD) begin
      case (in_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_load = 1'b1;
        default:                                in_load = 1'b0;
      endcase
    end
    if (in_op == OP_STORE) begin
      case (in_f3)
        3'b000, 3'b001, 3'b010: in_store = 1'b1;
        default:                in_store = 1'b0;
      endcase
    end
    in_illegal = !(in_load || in_store);
    // funct3[1:0] encodes the size for every legal load/store.
    case (in_f3[1:0])
      2'b01:   in_misaligned = addr[0];
      2'b10:   in_misaligned = (addr[1:0] != 2'b00);
      default: in_misaligned = 1'b0;
    endcase
  end

  // Byte-lane view of the latched request.
  logic [2:0]  f3_q;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    f3_q = instr_q[9:7];
    case (f3_q[1:0])
      2'b00: begin
        lane_strb  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{sd_q[7:0]}};
      end
      2'b01: begin
        lane_strb  = 4'b0011 << {addr_q[1], 1'b0};
        lane_wdata = {2{sd_q[15:0]}};
      end
      default: begin
        lane_strb  = 4'b1111;
        lane_wdata = sd_q;
      end
    endcase

    case (addr_q[1:0])
      2'b00:   rd_byte = mem_rdata[7:0];
      2'b01:   rd_byte = mem_rdata[15:8];
      2'b10:   rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = mem_rdata;
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = 32'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    sd_d    = sd_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    berr_d  = berr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 32'd0;
        if (start) begin
          instr_d = instruction;
          addr_d  = addr;
          sd_d    = store_data;
          we_d    = in_store;
          ld_d    = 32'd0;
          berr_d  = 1'b0;
          ill_d   = in_illegal;
          mis_d   = !in_illegal && in_misaligned;
          state_d = (in_illegal || in_misaligned) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          ld_d    = we_q ? 32'd0 : rd_ext;
          state_d = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
          berr_d  = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        ld_d    = 32'd0;
        mis_d   = 1'b0;
        ill_d   = 1'b0;
        berr_d  = 1'b0;
        cnt_d   = 32'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= 17'd0;
      addr_q  <= 32'd0;
      sd_q    <= 32'd0;
      we_q    <= 1'b0;
      cnt_q   <= 32'd0;
      ld_q    <= 32'd0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  // Bus outputs are forced to zero outside REQ so an idle bus is quiet.
  always_comb begin
    busy                = (state_q != S_IDLE);
    done                = (state_q == S_DONE);
    mem_req             = (state_q == S_REQ);
    mem_we              = mem_req && we_q;
    mem_addr            = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wstrb           = mem_we ? lane_strb : 4'd0;
    mem_wdata           = mem_we ? lane_wdata : 32'd0;
    load_data           = done ? ld_q : 32'd0;
    misaligned          = done && mis_q;
    illegal_instruction = done && ill_q;
    bus_error           = done && berr_q;
    state_dbg           = state_q;
    instr_dbg           = instr_q;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit on the consuming side of the ALU address path.
- Takes the effective address the ALU computes for load/store opcodes (rs1 + imm), the store data (rs2) and the 17-bit packed instruction field.
- Runs one word-aligned transaction on the data-memory bus with a valid/ready handshake.
- Returns either a sign-extended or zero-extended load result, or one of three exception flags: misaligned, illegal or bus error.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of REQ cycles without mem_ready before a bus error is raised. The value 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- instruction  in  17  packed field: [16:10] funct7, [9:7] funct3, [6:0] opcode.
- addr  in  32  effective address from the ALU.
- store_data  in  32  rs2 value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid when done=1.
- misaligned  out  1  address misaligned for the access size; valid with done.
- illegal_instruction  out  1  unsupported opcode/funct3; valid with done.
- bus_error  out  1  handshake timed out; valid with done.
- mem_req  out  1  bus request valid.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_wdata  out  32  store data replicated across byte lanes.
- mem_wstrb  out  4  byte-lane enables; 0000 on loads.
- mem_ready  in  1  bus accepts/completes the transfer in the current cycle.
- mem_rdata  in  32  read word; valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset: the edge with rst=1 forces IDLE. From the next cycle all outputs are 0 and the timeout counter is 0. This holds mid-transaction: mem_req drops with no completion and no done pulse.
- States: IDLE, REQ, DONE.
- IDLE, start=1: latch instruction, addr and store_data, then decode.
  - Supported opcodes: LOAD 0000011 with funct3 LB=000, LH=001, LW=010, LBU=100, LHU=101; STORE 0100011 with funct3 SB=000, SH=001, SW=010.
  - Anything else sets illegal_instruction; go to DONE with no bus request.
  - Misaligned when a halfword has addr[0]=1 or a word has addr[1:0]≠00. Set misaligned; go to DONE with no bus request.
  - Otherwise go to REQ.
  - Illegal takes precedence over misaligned; at most one flag is set.
- start while busy=1 is ignored; no queueing.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until the handshake completes.
  - The transfer completes on the edge where mem_req=1 and mem_ready=1. mem_rdata is captured on that edge; go to DONE.
  - Each REQ cycle without mem_ready increments the counter. When the counter reaches TIMEOUT_CYCLES with no ready: set bus_error, drop mem_req, go to DONE. A late ready is then ignored.
- DONE: done=1 and flags are valid for exactly one cycle, then IDLE. Flags and load_data clear to 0 in IDLE.
- Store strobes and data:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - SH: wstrb = 0011 << {addr[1], 0}; wdata = {2{sd[15:0]}}.
  - SW: wstrb = 1111; wdata = sd.
- Load extraction:
  - Byte lane addr[1:0], halfword lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Stores and all error completions return load_data=0.
- Latency: with mem_ready already high, start in cycle 0 gives req in cycle 1 and done in cycle 2, i.e. 2 cycles. Error completions without a bus request give done in cycle 1.
- Back-to-back: a new start is accepted in the IDLE cycle right after done.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ready in first REQ cycle -> mem_addr=0x100, wstrb=0000, done in cycle 2, load_data=0xDEADBEEF.
- LB addr=0x203 and LBU addr=0x203, rdata=0x80FF1234 -> LB load_data=0xFFFFFF80; LBU load_data=0x00000080.
- SH addr=0x302, store_data=0x0000ABCD, ready after 3 wait cycles -> mem_we=1, wstrb=1100, wdata=0xABCDABCD held 4 cycles, done, load_data=0.
- LW addr=0x101; separately SH addr=0x001 -> no mem_req, done in cycle 1 with misaligned=1. Opcode 0000011 with funct3=011 -> illegal_instruction=1, no mem_req.
- TIMEOUT_CYCLES=4, SW with mem_ready held 0 -> mem_req high 4 cycles then drops, done with bus_error=1.
- rst pulsed during REQ -> next cycle mem_req=0, busy=0, no done pulse; a following LW completes normally.
